// File: rtl/uart_tx_bridge.sv
// Transmit bridge: buffers 32-bit words in a FIFO and serialises them as
// bytes (raw or ASCII hex + newline) onto the board txdata/txclk/txready port.
module uart_tx_bridge #(
  parameter int DEPTH     = 4,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit HEX_ASCII = 1'b0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        full,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  txdata,
  output logic        txclk,
  input  logic        txready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [3:0] NBYTES = HEX_ASCII ? 4'd9 : 4'd4;

  typedef enum logic [2:0] {IDLE, WAIT, SETUP, STROBE, GAP} state_t;

  state_t        state, state_nx;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_nx;
  logic          push, pop;
  logic [31:0]   word_p0;
  logic [3:0]    idx, idx_nx;
  logic [7:0]    txdata_nx;
  logic          txclk_nx, busy_nx;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [3:0] i);
    logic [1:0]  k;
    logic [31:0] sh;
    if (HEX_ASCII) begin
      if (i >= 4'd8) return 8'h0A;
      sh = w >> (5'd28 - {i[2:0], 2'b00});
      return hex_char(sh[3:0]);
    end
    k  = LSB_FIRST ? i[1:0] : (2'd3 - i[1:0]);
    sh = w >> {k, 3'b000};
    return sh[7:0];
  endfunction

  // full is the registered view, so a write racing a pop while full is dropped
  assign push     = wr_en && !full;
  assign pop      = (state == IDLE) && (count != '0);
  assign count_nx = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (count != '0) state_nx = WAIT;
      WAIT:    if (txready) state_nx = SETUP;
      SETUP:   state_nx = STROBE;
      STROBE:  state_nx = GAP;
      GAP:     state_nx = ((idx + 4'd1) < NBYTES) ? WAIT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    txdata_nx = txdata;
    idx_nx    = idx;
    txclk_nx  = (state_nx == STROBE);
    busy_nx   = (count_nx != '0) || (state_nx != IDLE);
    if (pop) idx_nx = 4'd0;
    if ((state == WAIT) && txready) txdata_nx = byte_sel(word_p0, idx);
    if (state == GAP) idx_nx = idx + 4'd1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      idx      <= 4'd0;
      txdata   <= 8'h00;
      txclk    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count    <= count_nx;
      full     <= (count_nx == DEPTH_C);
      overflow <= overflow | (wr_en & full);
      idx      <= idx_nx;
      txdata   <= txdata_nx;
      txclk    <= txclk_nx;
      busy     <= busy_nx;
    end
  end

  // FIFO storage and shift register carry data only
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
    if (pop)  word_p0   <= mem[rptr];
  end

endmodule

// File: tb/tb_uart_tx_bridge.sv
// Directed bench for uart_tx_bridge: a raw LSB-first instance and a HEX instance.
module tb_uart_tx_bridge;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        r_wr_en = 1'b0, h_wr_en = 1'b0;
  logic [31:0] r_wr_data = '0, h_wr_data = '0;
  logic        r_txready = 1'b0, h_txready = 1'b1;
  logic        r_full, r_busy, r_ovf, r_txclk;
  logic        h_full, h_busy, h_ovf, h_txclk;
  logic [7:0]  r_txdata, h_txdata;

  int          total = 0;
  int          bad = 0;
  int          got;
  bit          wide;
  logic [7:0]  bytes [0:31];
  int          stamp [0:31];
  logic [7:0]  hexp  [0:8];

  always #5 clk = ~clk;

  uart_tx_bridge #(.DEPTH(4), .LSB_FIRST(1'b1), .HEX_ASCII(1'b0)) u_raw (
    .clk(clk), .nrst(nrst), .wr_en(r_wr_en), .wr_data(r_wr_data),
    .full(r_full), .busy(r_busy), .overflow(r_ovf),
    .txdata(r_txdata), .txclk(r_txclk), .txready(r_txready)
  );

  uart_tx_bridge #(.DEPTH(4), .LSB_FIRST(1'b1), .HEX_ASCII(1'b1)) u_hex (
    .clk(clk), .nrst(nrst), .wr_en(h_wr_en), .wr_data(h_wr_data),
    .full(h_full), .busy(h_busy), .overflow(h_ovf),
    .txdata(h_txdata), .txclk(h_txclk), .txready(h_txready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Collect up to n txclk pulses from one instance, stamping the cycle each appeared.
  task automatic collect(input bit hx, input int n, input int limit);
    logic prev;
    logic pulse;
    prev = 1'b0;
    got  = 0;
    wide = 1'b0;
    for (int t = 1; t <= limit && got < n; t++) begin
      @(negedge clk);
      pulse = hx ? h_txclk : r_txclk;
      if (pulse) begin
        if (prev) wide = 1'b1;
        else begin
          bytes[got] = hx ? h_txdata : r_txdata;
          stamp[got] = t;
          got++;
        end
      end
      prev = pulse;
    end
  endtask

  task automatic push_r(input logic [31:0] d);
    @(negedge clk);
    r_wr_en = 1'b1;
    r_wr_data = d;
    @(negedge clk);
    r_wr_en = 1'b0;
  endtask

  task automatic push_h(input logic [31:0] d);
    @(negedge clk);
    h_wr_en = 1'b1;
    h_wr_data = d;
    @(negedge clk);
    h_wr_en = 1'b0;
  endtask

  initial begin
    // reset, asynchronous
    #3 nrst = 1'b0;
    #1;
    chk("rst_txdata", {24'h0, r_txdata}, 32'h0);
    chk("rst_txclk", {31'h0, r_txclk}, 32'h0);
    chk("rst_full", {31'h0, r_full}, 32'h0);
    chk("rst_busy", {31'h0, r_busy}, 32'h0);
    chk("rst_ovf", {31'h0, r_ovf}, 32'h0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    // raw LSB-first, txready high
    r_txready = 1'b1;
    push_r(32'h44332211);
    collect(1'b0, 4, 40);
    chk("raw_cnt", got, 4);
    chk("raw_b0", {24'h0, bytes[0]}, 32'h11);
    chk("raw_b1", {24'h0, bytes[1]}, 32'h22);
    chk("raw_b2", {24'h0, bytes[2]}, 32'h33);
    chk("raw_b3", {24'h0, bytes[3]}, 32'h44);
    chk("raw_gap1", stamp[1] - stamp[0], 4);
    chk("raw_gap2", stamp[2] - stamp[1], 4);
    chk("raw_gap3", stamp[3] - stamp[2], 4);
    chk("raw_wide", {31'h0, wide}, 32'h0);
    chk("raw_busy_gap", {31'h0, r_busy}, 32'h1);
    @(negedge clk);
    chk("raw_clk_low", {31'h0, r_txclk}, 32'h0);
    chk("raw_busy_gap2", {31'h0, r_busy}, 32'h1);
    @(negedge clk);
    chk("raw_busy_done", {31'h0, r_busy}, 32'h0);
    chk("raw_txdata_hold", {24'h0, r_txdata}, 32'h44);

    // backpressure
    r_txready = 1'b0;
    push_r(32'hA5A5A5A5);
    collect(1'b0, 1, 50);
    chk("bp_no_pulse", got, 0);
    chk("bp_busy", {31'h0, r_busy}, 32'h1);
    r_txready = 1'b1;
    collect(1'b0, 1, 6);
    chk("bp_first", got, 1);
    chk("bp_data", {24'h0, bytes[0]}, 32'hA5);
    chk("bp_latency", {31'h0, (stamp[0] >= 2 && stamp[0] <= 3)}, 32'h1);
    collect(1'b0, 3, 20);
    chk("bp_rest", got, 3);
    repeat (3) @(negedge clk);
    chk("bp_idle", {31'h0, r_busy}, 32'h0);

    // overflow: the first word moves into the shifter, the next four fill the FIFO
    r_txready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 6) begin
        chk("ovf_full", {31'h0, r_full}, 32'h1);
        chk("ovf_pre", {31'h0, r_ovf}, 32'h0);
      end
      r_wr_en = 1'b1;
      r_wr_data = i;
    end
    @(negedge clk);
    r_wr_en = 1'b0;
    chk("ovf_set", {31'h0, r_ovf}, 32'h1);
    chk("ovf_full2", {31'h0, r_full}, 32'h1);
    r_txready = 1'b1;
    collect(1'b0, 20, 120);
    chk("ovf_cnt", got, 20);
    for (int j = 0; j < 20; j++)
      chk($sformatf("ovf_b%0d", j), {24'h0, bytes[j]}, (j % 4 == 0) ? (j / 4 + 1) : 0);
    collect(1'b0, 1, 30);
    chk("ovf_extra", got, 0);
    chk("ovf_full_clr", {31'h0, r_full}, 32'h0);
    chk("ovf_busy_clr", {31'h0, r_busy}, 32'h0);
    chk("ovf_sticky", {31'h0, r_ovf}, 32'h1);

    // HEX ASCII
    hexp[0] = 8'h44; hexp[1] = 8'h45; hexp[2] = 8'h41; hexp[3] = 8'h44;
    hexp[4] = 8'h42; hexp[5] = 8'h45; hexp[6] = 8'h45; hexp[7] = 8'h46;
    hexp[8] = 8'h0A;
    push_h(32'hDEADBEEF);
    collect(1'b1, 9, 60);
    chk("hex1_cnt", got, 9);
    for (int j = 0; j < 9; j++)
      chk($sformatf("hex1_b%0d", j), {24'h0, bytes[j]}, {24'h0, hexp[j]});
    for (int j = 0; j < 7; j++) hexp[j] = 8'h30;
    hexp[7] = 8'h46;
    hexp[8] = 8'h0A;
    push_h(32'h0000000F);
    collect(1'b1, 9, 60);
    chk("hex2_cnt", got, 9);
    for (int j = 0; j < 9; j++)
      chk($sformatf("hex2_b%0d", j), {24'h0, bytes[j]}, {24'h0, hexp[j]});

    // reset while txclk is high
    push_r(32'h12345678);
    collect(1'b0, 1, 20);
    chk("mid_pulse_seen", got, 1);
    #2 nrst = 1'b0;
    #1;
    chk("mid_txclk", {31'h0, r_txclk}, 32'h0);
    chk("mid_txdata", {24'h0, r_txdata}, 32'h0);
    chk("mid_busy", {31'h0, r_busy}, 32'h0);
    chk("mid_ovf", {31'h0, r_ovf}, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    collect(1'b0, 1, 40);
    chk("mid_no_pulse", got, 0);
    chk("mid_idle", {31'h0, r_busy}, 32'h0);
    chk("mid_empty", {31'h0, r_full}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
